// File: rtl/fifo_pkg.sv
// fifo_pkg: pointer code conversions and defaults shared by both FIFO clock domains
package fifo_pkg;

   localparam int DEF_ADD_SIZE = 4;
   localparam int GW = 32;

   // Values narrower than GW are zero-extended, so one function serves every pointer width.
   function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
      logic [GW-1:0] b;
      b = '0;
      for (int i = 0; i < GW; i++) b[i] = ^(g >> i);
      return b;
   endfunction

endpackage

// File: rtl/sync_r2w.sv
// sync_r2w: two-flop synchroniser bringing the read-domain Gray pointer into wclk
module sync_r2w #(
   parameter int W = 5
) (
   input  logic         wclk,
   input  logic         wrst,
   input  logic [W-1:0] rptr,
   output logic [W-1:0] wq2_rptr
);

   logic [W-1:0] wq1_q, wq2_q;

   // Gray coding guarantees at most one bit is in flight, so a plain flop pair is safe.
   always_ff @(posedge wclk) begin
      if (wrst) begin
         wq1_q <= '0;
         wq2_q <= '0;
      end else begin
         wq1_q <= rptr;
         wq2_q <= wq1_q;
      end
   end

   assign wq2_rptr = wq2_q;

endmodule

// File: rtl/wptr_full_ctrl.sv
// wptr_full_ctrl: write pointer, full/almost-full flags, fill level and overflow for the async FIFO
module wptr_full_ctrl
   import fifo_pkg::*;
#(
   parameter int ADD_SIZE     = DEF_ADD_SIZE,
   parameter int AFULL_THRESH = 14
) (
   input  logic                wclk,
   input  logic                wrst,
   input  logic                winc,
   input  logic                wovf_clr,
   input  logic [ADD_SIZE:0]   rptr,
   output logic [ADD_SIZE-1:0] waddr,
   output logic                wen,
   output logic [ADD_SIZE:0]   wptr,
   output logic                wfull,
   output logic                walmost_full,
   output logic [ADD_SIZE:0]   wlevel,
   output logic                woverflow
);

   localparam int PW = ADD_SIZE + 1;

   logic [PW-1:0] wbin_q, wbin_d, wgray_q, wgray_d, wlevel_q, wlevel_d, wq2_rptr;
   logic          wfull_q, wfull_d, wafull_q, wafull_d, wovf_q, wovf_d;

   sync_r2w #(.W(PW)) u_sync (
      .wclk     (wclk),
      .wrst     (wrst),
      .rptr     (rptr),
      .wq2_rptr (wq2_rptr)
   );

   assign wen = winc & ~wfull_q;

   // Next pointers and flags; full means the write pointer is one lap ahead of the synced read pointer.
   always_comb begin
      wbin_d   = wbin_q + PW'(wen);
      wgray_d  = PW'(bin2gray(GW'(wbin_d)));
      wlevel_d = wbin_d - PW'(gray2bin(GW'(wq2_rptr)));
      wfull_d  = wgray_d == {~wq2_rptr[PW-1:PW-2], wq2_rptr[PW-3:0]};
      wafull_d = wlevel_d >= PW'(AFULL_THRESH);
      wovf_d   = (winc & wfull_q) | (wovf_q & ~wovf_clr);
   end

   // State registers; a rejected write leaves the pointers untouched because wen is low.
   always_ff @(posedge wclk) begin
      if (wrst) begin
         wbin_q   <= '0;
         wgray_q  <= '0;
         wlevel_q <= '0;
         wfull_q  <= 1'b0;
         wafull_q <= 1'b0;
         wovf_q   <= 1'b0;
      end else begin
         wbin_q   <= wbin_d;
         wgray_q  <= wgray_d;
         wlevel_q <= wlevel_d;
         wfull_q  <= wfull_d;
         wafull_q <= wafull_d;
         wovf_q   <= wovf_d;
      end
   end

   assign waddr        = wbin_q[ADD_SIZE-1:0];
   assign wptr         = wgray_q;
   assign wfull        = wfull_q;
   assign walmost_full = wafull_q;
   assign wlevel       = wlevel_q;
   assign woverflow    = wovf_q;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// tb_wptr_full_ctrl: directed vector table plus hand sequences for the write-side FIFO controller
module tb_wptr_full_ctrl;

   logic       wclk = 1'b0;
   logic       wrst = 1'b1;
   logic       winc = 1'b0;
   logic       wovf_clr = 1'b0;
   logic [4:0] rptr = '0;
   logic [3:0] waddr;
   logic       wen, wfull, walmost_full, woverflow;
   logic [4:0] wptr, wlevel;

   int tests = 0;
   int fails = 0;

   typedef struct {
      bit         rst, inc, clr;
      logic [4:0] rp;
      logic [3:0] a;
      bit         en;
      logic [4:0] p;
      bit         f, af;
      logic [4:0] l;
      bit         o;
   } vec_t;

   vec_t vecs[$];

   wptr_full_ctrl #(.ADD_SIZE(4), .AFULL_THRESH(14)) dut (
      .wclk         (wclk),
      .wrst         (wrst),
      .winc         (winc),
      .wovf_clr     (wovf_clr),
      .rptr         (rptr),
      .waddr        (waddr),
      .wen          (wen),
      .wptr         (wptr),
      .wfull        (wfull),
      .walmost_full (walmost_full),
      .wlevel       (wlevel),
      .woverflow    (woverflow)
   );

   always #5 wclk = ~wclk;

   function automatic logic [4:0] g(input int b);
      int m;
      m = b & 31;
      return 5'(m ^ (m >> 1));
   endfunction

   function automatic vec_t v(bit rst, bit inc, bit clr, logic [4:0] rp, logic [3:0] a, bit en,
                              logic [4:0] p, bit f, bit af, logic [4:0] l, bit o);
      vec_t r;
      r.rst = rst; r.inc = inc; r.clr = clr; r.rp = rp; r.a = a; r.en = en;
      r.p = p; r.f = f; r.af = af; r.l = l; r.o = o;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step(input bit r, input bit i, input bit c, input logic [4:0] rp);
      wrst = r; winc = i; wovf_clr = c; rptr = rp;
      @(posedge wclk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic [3:0] a, input bit en, input logic [4:0] p,
                          input bit f, input bit af, input logic [4:0] l, input bit o);
      chk({tag, ".waddr"}, 32'(waddr), 32'(a));
      chk({tag, ".wen"}, 32'(wen), 32'(en));
      chk({tag, ".wptr"}, 32'(wptr), 32'(p));
      chk({tag, ".wfull"}, 32'(wfull), 32'(f));
      chk({tag, ".walmost_full"}, 32'(walmost_full), 32'(af));
      chk({tag, ".wlevel"}, 32'(wlevel), 32'(l));
      chk({tag, ".woverflow"}, 32'(woverflow), 32'(o));
   endtask

   initial begin
      logic [4:0] prev;
      // reset
      vecs.push_back(v(1,0,0,5'b00000, 4'd0, 0, 5'b00000, 0,0, 5'd0, 0));
      vecs.push_back(v(1,0,0,5'b00000, 4'd0, 0, 5'b00000, 0,0, 5'd0, 0));
      // fill with rptr = 0
      vecs.push_back(v(0,1,0,5'b00000, 4'd1,  1, 5'b00001, 0,0, 5'd1,  0));
      vecs.push_back(v(0,1,0,5'b00000, 4'd2,  1, 5'b00011, 0,0, 5'd2,  0));
      vecs.push_back(v(0,1,0,5'b00000, 4'd3,  1, 5'b00010, 0,0, 5'd3,  0));
      vecs.push_back(v(0,1,0,5'b00000, 4'd4,  1, 5'b00110, 0,0, 5'd4,  0));
      vecs.push_back(v(0,1,0,5'b00000, 4'd5,  1, 5'b00111, 0,0, 5'd5,  0));
      vecs.push_back(v(0,1,0,5'b00000, 4'd6,  1, 5'b00101, 0,0, 5'd6,  0));
      vecs.push_back(v(0,1,0,5'b00000, 4'd7,  1, 5'b00100, 0,0, 5'd7,  0));
      vecs.push_back(v(0,1,0,5'b00000, 4'd8,  1, 5'b01100, 0,0, 5'd8,  0));
      vecs.push_back(v(0,1,0,5'b00000, 4'd9,  1, 5'b01101, 0,0, 5'd9,  0));
      vecs.push_back(v(0,1,0,5'b00000, 4'd10, 1, 5'b01111, 0,0, 5'd10, 0));
      vecs.push_back(v(0,1,0,5'b00000, 4'd11, 1, 5'b01110, 0,0, 5'd11, 0));
      vecs.push_back(v(0,1,0,5'b00000, 4'd12, 1, 5'b01010, 0,0, 5'd12, 0));
      vecs.push_back(v(0,1,0,5'b00000, 4'd13, 1, 5'b01011, 0,0, 5'd13, 0));
      vecs.push_back(v(0,1,0,5'b00000, 4'd14, 1, 5'b01001, 0,1, 5'd14, 0));
      vecs.push_back(v(0,1,0,5'b00000, 4'd15, 1, 5'b01000, 0,1, 5'd15, 0));
      vecs.push_back(v(0,1,0,5'b00000, 4'd0,  0, 5'b11000, 1,1, 5'd16, 0));
      // writes while full are rejected and flag overflow
      vecs.push_back(v(0,1,0,5'b00000, 4'd0, 0, 5'b11000, 1,1, 5'd16, 1));
      vecs.push_back(v(0,1,0,5'b00000, 4'd0, 0, 5'b11000, 1,1, 5'd16, 1));
      vecs.push_back(v(0,1,0,5'b00000, 4'd0, 0, 5'b11000, 1,1, 5'd16, 1));
      vecs.push_back(v(0,0,1,5'b00000, 4'd0, 0, 5'b11000, 1,1, 5'd16, 0));
      vecs.push_back(v(0,1,1,5'b00000, 4'd0, 0, 5'b11000, 1,1, 5'd16, 1));
      vecs.push_back(v(0,0,0,5'b00000, 4'd0, 0, 5'b11000, 1,1, 5'd16, 1));
      vecs.push_back(v(0,0,1,5'b00000, 4'd0, 0, 5'b11000, 1,1, 5'd16, 0));
      // read pointer moves to gray(4): flags follow on the third edge only
      vecs.push_back(v(0,0,0,5'b00110, 4'd0, 0, 5'b11000, 1,1, 5'd16, 0));
      vecs.push_back(v(0,0,0,5'b00110, 4'd0, 0, 5'b11000, 1,1, 5'd16, 0));
      vecs.push_back(v(0,0,0,5'b00110, 4'd0, 0, 5'b11000, 0,0, 5'd12, 0));
      vecs.push_back(v(0,1,0,5'b00110, 4'd1, 1, 5'b11001, 0,0, 5'd13, 0));

      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].inc, vecs[i].clr, vecs[i].rp);
         chk_all($sformatf("vec%0d", i), vecs[i].a, vecs[i].en, vecs[i].p,
                 vecs[i].f, vecs[i].af, vecs[i].l, vecs[i].o);
      end

      // streaming with rptr following the write count; pointer wraps 31 -> 0
      step(1, 0, 0, 5'b00000);
      step(1, 0, 0, 5'b00000);
      for (int k = 0; k < 40; k++) begin
         prev = wptr;
         step(0, 1, 0, g(k));
         chk($sformatf("stream%0d.waddr", k), 32'(waddr), 32'((k + 1) & 15));
         chk($sformatf("stream%0d.hamming", k), 32'($countones(prev ^ wptr)), 32'd1);
         chk($sformatf("stream%0d.wfull", k), 32'(wfull), 32'd0);
         if (k >= 1)
            chk($sformatf("stream%0d.wlevel_range", k), 32'(wlevel >= 5'd2 && wlevel <= 5'd4), 32'd1);
         if (k == 31)
            chk("stream.wrap_wptr", 32'(wptr), 32'd0);
      end

      // build up to level 9 then reset mid-stream
      for (int k = 0; k < 3; k++) step(0, 0, 0, g(39));
      chk("idle.wlevel", 32'(wlevel), 32'd1);
      for (int k = 0; k < 8; k++) step(0, 1, 0, g(39));
      chk("pre_rst.wlevel", 32'(wlevel), 32'd9);
      chk("pre_rst.waddr", 32'(waddr), 32'd0);
      step(1, 0, 0, g(39));
      chk_all("midrst", 4'd0, 0, 5'b00000, 0, 0, 5'd0, 0);
      step(0, 0, 0, 5'b00000);
      winc = 1'b1;
      #1;
      chk("resume.wen", 32'(wen), 32'd1);
      chk("resume.waddr_pre", 32'(waddr), 32'd0);
      @(posedge wclk);
      #1;
      chk("resume.waddr", 32'(waddr), 32'd1);
      chk("resume.wptr", 32'(wptr), 32'd1);
      chk("resume.wlevel", 32'(wlevel), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
